// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int REG_T9     = 25;

  typedef enum logic [0:0] {
    ARB_NORMAL    = 1'b0,
    ARB_FORCE_EXT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } ext_req_t;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// Small synchronous FIFO holding queued external register writes.
// The head entry is read combinationally so the arbiter can grant it and
// capture its data in the same cycle.
module ext_wr_fifo #(
  parameter  int WIDTH = 37,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];
  // Guard against overflow and underflow regardless of caller behaviour.
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !o_empty;

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between CPU writeback
// (priority) and queued external loader writes, with anti-starvation.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int ADDR_W       = DEF_ADDR_W,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int CW           = $clog2(FIFO_DEPTH + 1),
  localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic [ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              cpu_stall,
  output logic [CW-1:0]     fifo_count
);

  arb_state_t        r_state;
  logic [SW-1:0]     r_starve;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_cpu_stall;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic                     w_grant_cpu;
  logic                     w_grant;
  logic [ADDR_W-1:0]        w_gnt_addr;
  logic [DATA_W-1:0]        w_gnt_data;
  logic [SW-1:0]            w_starve_next;
  logic                     w_force;

  // Ready depends only on registered occupancy; held low during reset.
  assign ext_ready = !w_full && !reset;
  assign w_push    = ext_valid && ext_ready;

  ext_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({ext_waddr, ext_wdata}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count)
  );

  // Grant selection and starvation tracking for the current cycle.
  always_comb begin
    w_grant_cpu   = (r_state == ARB_NORMAL) && cpu_we;
    w_pop         = !w_empty && ((r_state == ARB_FORCE_EXT) || !cpu_we);
    w_grant       = w_grant_cpu || w_pop;
    w_gnt_addr    = w_grant_cpu ? cpu_waddr : w_head[ADDR_W+DATA_W-1:DATA_W];
    w_gnt_data    = w_grant_cpu ? cpu_wdata : w_head[DATA_W-1:0];
    w_starve_next = '0;
    if ((r_state == ARB_NORMAL) && !w_empty && !w_pop) begin
      w_starve_next = r_starve + SW'(1);
    end
    w_force = (r_state == ARB_NORMAL) && (w_starve_next == SW'(STARVE_LIMIT));
  end

  // FSM, starve counter and registered write-port outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_NORMAL;
      r_starve    <= '0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_cpu_stall <= 1'b0;
    end else begin
      r_state     <= w_force ? ARB_FORCE_EXT : ARB_NORMAL;
      r_cpu_stall <= w_force;
      r_starve    <= w_starve_next;
      // Register 0 writes are consumed but never reach the register file.
      r_rf_we     <= w_grant && (w_gnt_addr != ADDR_W'(REG_ZERO));
      if (w_grant) begin
        r_rf_waddr <= w_gnt_addr;
        r_rf_wdata <= w_gnt_data;
      end
    end
  end

  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign cpu_stall = r_cpu_stall;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a
// queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int FD = 4;
  localparam int SL = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [4:0]  cpu_waddr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        ext_valid = 1'b0;
  logic        ext_ready;
  logic [4:0]  ext_waddr = '0;
  logic [31:0] ext_wdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cpu_stall;
  logic [2:0]  fifo_count;

  regfile_write_arbiter #(
    .DATA_W (32), .ADDR_W (5), .FIFO_DEPTH (FD), .STARVE_LIMIT (SL)
  ) dut (
    .clock (clock), .reset (reset),
    .cpu_we (cpu_we), .cpu_waddr (cpu_waddr), .cpu_wdata (cpu_wdata),
    .ext_valid (ext_valid), .ext_ready (ext_ready),
    .ext_waddr (ext_waddr), .ext_wdata (ext_wdata),
    .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
    .cpu_stall (cpu_stall), .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ext_req_t    m_q[$];
  int          m_starve = 0;
  bit          m_force  = 0;
  bit          m_pushed = 0;
  bit          e_we = 0;
  logic [4:0]  e_addr = '0;
  logic [31:0] e_data = '0;
  bit          e_stall = 0;
  bit          ignored = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of the arbitration rules applied to the current inputs.
  task automatic model_step();
    bit had, ready, popped, gnt, nf;
    ext_req_t g;
    m_pushed = 0;
    if (reset) begin
      m_q.delete();
      m_starve = 0; m_force = 0;
      e_we = 0; e_addr = '0; e_data = '0; e_stall = 0;
      return;
    end
    had = (m_q.size() > 0);
    ready = (m_q.size() < FD);
    popped = 0; gnt = 0; g = '0;
    if (!m_force && cpu_we) begin
      gnt = 1; g.addr = cpu_waddr; g.data = cpu_wdata;
    end else if (had) begin
      g = m_q.pop_front(); gnt = 1; popped = 1;
    end
    if (!m_force && had && !popped) m_starve++;
    else m_starve = 0;
    nf = !m_force && (m_starve == SL);
    if (ext_valid && ready) begin
      m_q.push_back('{addr: ext_waddr, data: ext_wdata});
      m_pushed = 1;
    end
    e_we = gnt && (g.addr != 5'd0);
    if (gnt) begin e_addr = g.addr; e_data = g.data; end
    e_stall = nf;
    m_force = nf;
  endtask

  // Apply inputs, advance one clock, compare all outputs with the model.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ev, input logic [4:0] ea, input logic [31:0] ed);
    bit was_force;
    cpu_we = we; cpu_waddr = wa; cpu_wdata = wd;
    ext_valid = ev; ext_waddr = ea; ext_wdata = ed;
    was_force = m_force;
    model_step();
    ignored = was_force && we && !reset;
    @(posedge clock); #1;
    check("rf_we", 64'(rf_we), 64'(e_we));
    if (e_we) begin
      check("rf_waddr", 64'(rf_waddr), 64'(e_addr));
      check("rf_wdata", 64'(rf_wdata), 64'(e_data));
    end
    check("cpu_stall", 64'(cpu_stall), 64'(e_stall));
    check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    check("ext_ready", 64'(ext_ready), 64'(!reset && (m_q.size() < FD)));
    if (rf_we) $display("t=%0t write r%0d <= %h stall=%0b count=%0d",
                        $time, rf_waddr, rf_wdata, cpu_stall, fifo_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    int stalls;
    bit pend, pw;
    logic [4:0]  pa;
    logic [31:0] pd;

    #1;
    // Reset held with ext_valid asserted
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 1, 5'd3, 32'h1);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    reset = 1'b0;

    // CPU-only write
    cycle(1, 5'd8, 32'h1234, 0, '0, '0);
    check("cpu_only_we", 64'(rf_we), 64'd1);
    check("cpu_only_data", 64'(rf_wdata), 64'h1234);

    // External write in idle cycles: visible two clocks after push
    cycle(0, '0, '0, 1, 5'(REG_T9), 32'hA5);
    check("ext_not_yet", 64'(rf_we), 64'd0);
    cycle(0, '0, '0, 0, '0, '0);
    check("ext_t9_addr", 64'(rf_waddr), 64'(REG_T9));
    check("ext_t9_data", 64'(rf_wdata), 64'hA5);
    idle(2);

    // Fill the FIFO while the CPU keeps the port busy
    for (int i = 0; i < FD; i++) cycle(1, 5'd9, 32'h100 + i, 1, 5'(10 + i), 32'h200 + i);
    check("full_not_ready", 64'(ext_ready), 64'd0);
    pend = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 5'd9, 32'h300 + i, 1, 5'd20, 32'h2FF);
      if (m_pushed) begin pend = 1; break; end
    end
    check("fifth_accepted", 64'(pend), 64'd1);
    idle(8);

    // Starvation with one queued entry and a continuously busy CPU
    stalls = 0;
    cycle(1, 5'd4, 32'h400, 1, 5'(REG_T9), 32'hBEEF);
    pd = 32'h401;
    for (int i = 0; i < 14; i++) begin
      cycle(1, 5'd4, pd, 0, '0, '0);
      if (cpu_stall) stalls++;
      if (!ignored) pd = pd + 1;
    end
    check("starve_stalls", 64'(stalls), 64'd1);
    idle(2);

    // Register-zero write is consumed silently
    cycle(0, '0, '0, 1, 5'd0, 32'hDEAD);
    idle(3);

    // Reset while entries are queued
    for (int i = 0; i < 3; i++) cycle(1, 5'd6, 32'h600 + i, 1, 5'(1 + i), 32'h700 + i);
    reset = 1'b1;
    cycle(0, '0, '0, 0, '0, '0);
    reset = 1'b0;
    idle(4);
    check("post_reset_count", 64'(fifo_count), 64'd0);

    // Randomised traffic; the CPU re-presents any write ignored by a stall
    pend = 0; pw = 0; pa = '0; pd = '0;
    for (int i = 0; i < 500; i++) begin
      if (!pend) begin
        pw = ($urandom_range(0, 99) < 65);
        pa = 5'($urandom);
        pd = $urandom;
      end
      reset = ($urandom_range(0, 249) == 0);
      cycle(pw, pa, pd, ($urandom_range(0, 99) < 45), 5'($urandom), $urandom);
      pend = ignored;
      reset = 1'b0;
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
